mips_multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the MIPS datapath: a Moore state machine that replaces the single-cycle control unit when instruction fetch, register file, ALU and data memory share one memory port and one ALU over several cycles. It decodes `op`/`funct` from the external instruction register and drives every datapath mux select and write strobe each cycle. It stalls on a memory-ready handshake and reports instruction completion and illegal encodings.

---
 rtl/mips_multicycle_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Multi-cycle MIPS sequencing controller. A Moore FSM that
//                steps lw/sw/R-type/beq/addi/j through a shared memory port
//                and ALU. It drives every datapath mux select and write
//                strobe each cycle and stalls on mem_ready.
//  Ports       : clk, rst (async, active-high)
//                op, funct        - instruction fields from the IR
//                zero             - ALU zero flag (beq resolution)
//                mem_ready        - memory access completes this cycle
//                IorD, IRWrite, MemWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
//                ALUControl, RegWrite, RegDst, MemtoReg - datapath control
//                instr_done       - final cycle of each instruction
//                illegal          - unsupported encoding seen in DECODE
//                state_dbg        - current state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl #(
    parameter int FSM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             PCEn,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             instr_done,
    output logic             illegal,
    output logic [FSM_W-1:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [2:0] c_ALU_ADD  = 3'b010;
    localparam logic [2:0] c_ALU_SUB  = 3'b110;
    localparam logic [2:0] c_ALU_AND  = 3'b000;
    localparam logic [2:0] c_ALU_OR   = 3'b001;
    localparam logic [2:0] c_ALU_SLT  = 3'b111;

    state_t     r_state;
    state_t     w_next;

    logic       w_funct_ok;
    logic [2:0] w_alu_funct;

    // Unqualified strobes; reset gating is applied at the output ports.
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_regwrite;
    logic       w_done;
    logic       w_illegal;

    // R-type funct decode, shared by DECODE (legality) and EXEC (ALU op).
    always_comb begin
        w_funct_ok  = 1'b1;
        w_alu_funct = c_ALU_ADD;
        case (funct)
            6'b100000: w_alu_funct = c_ALU_ADD;
            6'b100010: w_alu_funct = c_ALU_SUB;
            6'b100100: w_alu_funct = c_ALU_AND;
            6'b100101: w_alu_funct = c_ALU_OR;
            6'b101010: w_alu_funct = c_ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        IorD       = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = c_ALU_ADD;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_regwrite = 1'b0;
        w_done     = 1'b0;
        w_illegal  = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ALUSrcB = 2'b11;
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_RTYPE: begin
                        if (w_funct_ok) begin
                            w_next = S_EXEC;
                        end else begin
                            w_next    = S_FETCH;
                            w_illegal = 1'b1;
                            w_done    = 1'b1;
                        end
                    end
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                        w_done    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                w_memwrite = mem_ready;
                w_done     = mem_ready;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = w_alu_funct;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = c_ALU_SUB;
                PCSrc      = 2'b01;
                w_branch   = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // State is already FETCH during reset, so only the strobes need masking
    // (FETCH would otherwise raise IRWrite/PCEn on mem_ready).
    assign IRWrite    = w_irwrite  & ~rst;
    assign MemWrite   = w_memwrite & ~rst;
    assign PCEn       = (w_pcwrite | (w_branch & zero)) & ~rst;
    assign RegWrite   = w_regwrite & ~rst;
    assign instr_done = w_done     & ~rst;
    assign illegal    = w_illegal  & ~rst;
    assign state_dbg  = FSM_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
//  Module      : tb_mips_multicycle_ctrl
//  Description : Self-checking bench for mips_multicycle_ctrl. A per-cycle
//                table of {inputs, expected state, expected controls} is
//                applied in order, followed by a hand-written reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       IorD, IRWrite, MemWrite, PCEn, ALUSrcA, RegWrite, RegDst, MemtoReg;
    logic       instr_done, illegal;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    mips_multicycle_ctrl #(.FSM_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .PCEn       (PCEn),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout:
    // {IorD,IRWrite,MemWrite,PCEn}_{PCSrc}_{ALUSrcA}_{ALUSrcB}_{ALUControl}_
    // {RegWrite,RegDst,MemtoReg}_{instr_done,illegal}
    logic [16:0] w_act;
    assign w_act = {IorD, IRWrite, MemWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                    ALUControl, RegWrite, RegDst, MemtoReg, instr_done, illegal};

    localparam logic [16:0] c_E_FETCH   = 17'b0101_00_0_01_010_000_00;
    localparam logic [16:0] c_E_FSTALL  = 17'b0000_00_0_01_010_000_00;
    localparam logic [16:0] c_E_DEC     = 17'b0000_00_0_11_010_000_00;
    localparam logic [16:0] c_E_DECILL  = 17'b0000_00_0_11_010_000_11;
    localparam logic [16:0] c_E_MEMADR  = 17'b0000_00_1_10_010_000_00;
    localparam logic [16:0] c_E_MEMRD   = 17'b1000_00_0_00_010_000_00;
    localparam logic [16:0] c_E_MEMWB   = 17'b0000_00_0_00_010_101_10;
    localparam logic [16:0] c_E_MEMWR   = 17'b1010_00_0_00_010_000_10;
    localparam logic [16:0] c_E_MWSTALL = 17'b1000_00_0_00_010_000_00;
    localparam logic [16:0] c_E_ALUWB   = 17'b0000_00_0_00_010_110_10;
    localparam logic [16:0] c_E_BR_T    = 17'b0001_01_1_00_110_000_10;
    localparam logic [16:0] c_E_BR_NT   = 17'b0000_01_1_00_110_000_10;
    localparam logic [16:0] c_E_ADDIEX  = 17'b0000_00_1_10_010_000_00;
    localparam logic [16:0] c_E_ADDIWB  = 17'b0000_00_0_00_010_100_10;
    localparam logic [16:0] c_E_JUMP    = 17'b0001_10_0_00_010_000_10;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] ctl;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic m, input logic [3:0] s, input logic [16:0] c,
                       input string n);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.mr = m; v.st = s; v.ctl = c; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [3:0] s, input logic [16:0] c);
        checks++;
        if (state_dbg !== s || w_act !== c) begin
            errors++;
            $display("FAIL %s: state=%0d ctl=%b, required state=%0d ctl=%b",
                     n, state_dbg, w_act, s, c);
        end
    endtask

    function automatic logic [16:0] exec_ctl(input logic [2:0] alu);
        return {4'b0000, 2'b00, 1'b1, 2'b00, alu, 3'b000, 2'b00};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rfunct[5];
        logic [2:0] ralu[5];
        rfunct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ralu   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

        // R-type sweep: FETCH, DECODE, EXEC, ALUWB
        for (int i = 0; i < 5; i++) begin
            add(6'b000000, rfunct[i], 1'b0, 1'b1, 4'd0, c_E_FETCH, "rtype_fetch");
            add(6'b000000, rfunct[i], 1'b0, 1'b1, 4'd1, c_E_DEC, "rtype_decode");
            add(6'b000000, rfunct[i], 1'b0, 1'b1, 4'd6, exec_ctl(ralu[i]), "rtype_exec");
            add(6'b000000, rfunct[i], 1'b0, 1'b1, 4'd7, c_E_ALUWB, "rtype_aluwb");
        end
        // lw with two stall cycles in FETCH and in MEMRD: 9 cycles
        add(6'b100011, 6'd0, 1'b0, 1'b0, 4'd0, c_E_FSTALL, "lw_fetch_stall1");
        add(6'b100011, 6'd0, 1'b0, 1'b0, 4'd0, c_E_FSTALL, "lw_fetch_stall2");
        add(6'b100011, 6'd0, 1'b0, 1'b1, 4'd0, c_E_FETCH, "lw_fetch");
        add(6'b100011, 6'd0, 1'b0, 1'b1, 4'd1, c_E_DEC, "lw_decode");
        add(6'b100011, 6'd0, 1'b0, 1'b1, 4'd2, c_E_MEMADR, "lw_memadr");
        add(6'b100011, 6'd0, 1'b0, 1'b0, 4'd3, c_E_MEMRD, "lw_memrd_stall1");
        add(6'b100011, 6'd0, 1'b0, 1'b0, 4'd3, c_E_MEMRD, "lw_memrd_stall2");
        add(6'b100011, 6'd0, 1'b0, 1'b1, 4'd3, c_E_MEMRD, "lw_memrd");
        add(6'b100011, 6'd0, 1'b0, 1'b1, 4'd4, c_E_MEMWB, "lw_memwb");
        // beq taken, then not taken
        add(6'b000100, 6'd0, 1'b1, 1'b1, 4'd0, c_E_FETCH, "beq1_fetch");
        add(6'b000100, 6'd0, 1'b1, 1'b1, 4'd1, c_E_DEC, "beq1_decode");
        add(6'b000100, 6'd0, 1'b1, 1'b1, 4'd8, c_E_BR_T, "beq1_branch");
        add(6'b000100, 6'd0, 1'b0, 1'b1, 4'd0, c_E_FETCH, "beq0_fetch");
        add(6'b000100, 6'd0, 1'b0, 1'b1, 4'd1, c_E_DEC, "beq0_decode");
        add(6'b000100, 6'd0, 1'b0, 1'b1, 4'd8, c_E_BR_NT, "beq0_branch");
        // sw with one write stall, then j
        add(6'b101011, 6'd0, 1'b0, 1'b1, 4'd0, c_E_FETCH, "sw_fetch");
        add(6'b101011, 6'd0, 1'b0, 1'b1, 4'd1, c_E_DEC, "sw_decode");
        add(6'b101011, 6'd0, 1'b0, 1'b1, 4'd2, c_E_MEMADR, "sw_memadr");
        add(6'b101011, 6'd0, 1'b0, 1'b0, 4'd5, c_E_MWSTALL, "sw_memwr_stall");
        add(6'b101011, 6'd0, 1'b0, 1'b1, 4'd5, c_E_MEMWR, "sw_memwr");
        add(6'b000010, 6'd0, 1'b0, 1'b1, 4'd0, c_E_FETCH, "j_fetch");
        add(6'b000010, 6'd0, 1'b0, 1'b1, 4'd1, c_E_DEC, "j_decode");
        add(6'b000010, 6'd0, 1'b0, 1'b1, 4'd11, c_E_JUMP, "j_jump");
        // addi
        add(6'b001000, 6'd0, 1'b0, 1'b1, 4'd0, c_E_FETCH, "addi_fetch");
        add(6'b001000, 6'd0, 1'b0, 1'b1, 4'd1, c_E_DEC, "addi_decode");
        add(6'b001000, 6'd0, 1'b0, 1'b1, 4'd9, c_E_ADDIEX, "addi_ex");
        add(6'b001000, 6'd0, 1'b0, 1'b1, 4'd10, c_E_ADDIWB, "addi_wb");
        // illegal op, then R-type with unsupported funct
        add(6'b111111, 6'd0, 1'b0, 1'b1, 4'd0, c_E_FETCH, "ill_op_fetch");
        add(6'b111111, 6'd0, 1'b0, 1'b1, 4'd1, c_E_DECILL, "ill_op_decode");
        add(6'b000000, 6'd0, 1'b0, 1'b1, 4'd0, c_E_FETCH, "ill_fn_fetch");
        add(6'b000000, 6'd0, 1'b0, 1'b1, 4'd1, c_E_DECILL, "ill_fn_decode");
        add(6'b000000, 6'd0, 1'b0, 1'b1, 4'd0, c_E_FETCH, "ill_fn_refetch");

        // Reset with mem_ready high: strobes must be masked
        rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1 check("reset_state", 4'd0, c_E_FSTALL);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op; funct = vecs[i].funct;
            zero = vecs[i].zero; mem_ready = vecs[i].mr;
            #1 check(vecs[i].name, vecs[i].st, vecs[i].ctl);
            @(negedge clk);
        end

        // Reset asserted mid-EXEC, then released
        op = 6'b000000; funct = 6'b100010; zero = 1'b0; mem_ready = 1'b1;
        #1 check("rst_seq_decode", 4'd1, c_E_DEC);
        @(negedge clk);
        #1 check("rst_seq_exec", 4'd6, exec_ctl(3'b110));
        #1 rst = 1'b1;
        #1 check("rst_async_entry", 4'd0, c_E_FSTALL);
        @(negedge clk);
        #1 check("rst_held", 4'd0, c_E_FSTALL);
        rst = 1'b0;
        #1 check("rst_release_fetch", 4'd0, c_E_FETCH);
        @(negedge clk);
        #1 check("rst_release_decode", 4'd1, c_E_DEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
